hazard_stall_sequencer: RTL and testbench
=========================================

# hazard_stall_sequencer

- Sequences the decode-stage pipeline-control signals: PC write enable, IF/ID write enable, ID/EX bubble select and IF/ID flush.
- Detects load-use and branch-operand hazards against the ID/EX and EX/MEM registers and derives a stall length of 0–2 cycles.
- Holds the IF/ID instruction for that many cycles through a small FSM, then flushes the wrong-path fetch on taken branches and jumps resolved in decode.
- Sits beside the decode phase and drives the PC register, the IF/ID register and the ID/EX control mux.

## Interface
Parameters:
- CNT_W, 16, width of the stall performance counter (used only with the counter compiled in)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- IF_IDRs  in  5  rs field of the instruction in IF/ID
- IF_IDRt  in  5  rt field of the instruction in IF/ID
- IF_IDUsesRt  in  1  instruction reads rt (R-type, store, beq)
- IF_IDBranch  in  1  instruction in ID is a conditional branch
- IF_IDJumpReg  in  1  instruction in ID is jr
- BranchTaken  in  1  comparator result says the branch is taken this cycle
- Jump  in  1  instruction in ID is j/jal
- ID_EXRegWrite  in  1  instruction in EX writes a register
- ID_EXMemRead  in  1  instruction in EX is a load
- ID_EXRegDst  in  5  destination register of the instruction in EX
- EX_MemMemRead  in  1  instruction in MEM is a load
- EX_MemRegDst  in  5  destination register of the instruction in MEM
- PCWrite  out  1  PC update enable
- IF_IDWrite  out  1  IF/ID update enable
- HazardDetect_Mux  out  1  1 = insert a bubble (zero all control) into ID/EX
- IF_IDFlush  out  1  1 = IF/ID captures a nop at the next edge
- StallCycles  out  CNT_W  stall cycles since reset (counter builds only)

## Operation
Match rule: a source register matches a destination only if the destination is nonzero and equals rs, or equals rt with IF_IDUsesRt=1.

Stall length N (the maximum of all applicable cases):
- N=1: ID_EXMemRead and a match (load-use).
- N=1: (IF_IDBranch or IF_IDJumpReg) and ID_EXRegWrite and not ID_EXMemRead and a match on ID_EXRegDst.
- N=2: (IF_IDBranch or IF_IDJumpReg) and ID_EXMemRead and a match.
- N=1: (IF_IDBranch or IF_IDJumpReg) and EX_MemMemRead and a match on EX_MemRegDst.
- For jr, only rs is compared.

FSM states:
- RUN: outputs are Mealy on the hazard computation.
  - N≥1: PCWrite=0, IF_IDWrite=0, HazardDetect_Mux=1, IF_IDFlush=0.
  - N=2: go to STALL with Rem=N-2=0.
  - N=0: PCWrite=1, IF_IDWrite=1, HazardDetect_Mux=0, and IF_IDFlush=(IF_IDBranch&BranchTaken)|Jump|IF_IDJumpReg.
- STALL: stall outputs are forced and all inputs are ignored.
  - Rem==0: go to RUN.
  - Otherwise: Rem decrements.

Conflict resolution:
- A stall overrides a flush; the branch re-resolves after the stall with forwarded-ready operands.
- Flush and IF_IDWrite=1 are asserted together; IF/ID gives flush priority.

## Timing
- Reset low, at any time including mid-stall: state=RUN, Rem=0, StallCycles=0. The outputs are forced to PCWrite=1, IF_IDWrite=1, HazardDetect_Mux=0 and IF_IDFlush=0 until the first edge after release.
- Hazard response has zero-cycle latency: detection and the stall output occur in the same cycle.
- A load-use hazard stalls exactly 1 cycle; a branch depending on a load in EX stalls exactly 2 consecutive cycles.
- Flush is a single cycle, asserted in the ID resolution cycle.
- Back-to-back hazards are allowed: RUN re-evaluates on the cycle after STALL, with no forced idle cycle.

## Configuration
- STALL_COUNTER_EN defined: StallCycles increments on every cycle with PCWrite=0 (outside reset) and saturates at 2^CNT_W-1.
- STALL_COUNTER_EN undefined: the counter register is not built and StallCycles is tied to 0.

## Structure
- Shared package holds:
  - the state enum {RUN, STALL};
  - the constants LOAD_USE_STALL=1, BR_ALU_STALL=1, BR_LOAD_EX_STALL=2, BR_LOAD_MEM_STALL=1;
  - REG_ZERO=5'd0.
- One sub-module, hazard_stall_calc: purely combinational N computation (2-bit output). The FSM, output logic and counter live in the top module.

## Test plan
- Load-use:
  - Stimulus: ID_EXMemRead=1, ID_EXRegDst=8, IF_IDRs=8.
  - Response: one cycle of PCWrite=0, IF_IDWrite=0, HazardDetect_Mux=1; the next cycle with clean inputs returns PCWrite=1.
- Branch after load:
  - Stimulus: IF_IDBranch=1, IF_IDRt=9, IF_IDUsesRt=1, ID_EXMemRead=1, ID_EXRegDst=9.
  - Response: exactly 2 stall cycles, with STALL ignoring inputs that are zeroed in cycle 2.
- Register $0:
  - Stimulus: ID_EXMemRead=1, ID_EXRegDst=0, IF_IDRs=0.
  - Response: no stall.
- Branch taken, with and without hazard:
  - Stimulus: IF_IDBranch=1, BranchTaken=1, no hazard.
  - Response: IF_IDFlush=1 for one cycle.
  - Stimulus: the same with an ALU hazard on rs.
  - Response: IF_IDFlush=0 and one stall cycle.
- Reset mid-stall:
  - Stimulus: Reset low during the STALL cycle.
  - Response: immediately PCWrite=1, HazardDetect_Mux=0, StallCycles=0; after release the FSM is in RUN.
- Counter (STALL_COUNTER_EN):
  - Stimulus: 3 hazard sequences totalling 4 stall cycles.
  - Response: StallCycles=4; saturation holds at 0xFFFF when forced near its limit with CNT_W=16.

Source files
------------

// File: rtl/hazard_stall_sequencer_pkg.sv
// ============================================================================
// Module : hazard_stall_sequencer_pkg
// Brief  : Shared types, stall-length constants and register-match helper
//          for the decode-stage hazard stall sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_stall_sequencer_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   localparam logic [1:0] LOAD_USE_STALL    = 2'd1;
   localparam logic [1:0] BR_ALU_STALL      = 2'd1;
   localparam logic [1:0] BR_LOAD_EX_STALL  = 2'd2;
   localparam logic [1:0] BR_LOAD_MEM_STALL = 2'd1;
   localparam logic [4:0] REG_ZERO          = 5'd0;

   // $0 is hardwired, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] dst,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       use_rt);
      return (dst != REG_ZERO) && ((dst == rs) || (use_rt && (dst == rt)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_sequencer_if.sv
// ============================================================================
// Module : hazard_stall_sequencer_if
// Brief  : Decode-stage hazard inputs and pipeline-control outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_stall_sequencer_if;
   logic [4:0] IF_IDRs;
   logic [4:0] IF_IDRt;
   logic       IF_IDUsesRt;
   logic       IF_IDBranch;
   logic       IF_IDJumpReg;
   logic       BranchTaken;
   logic       Jump;
   logic       ID_EXRegWrite;
   logic       ID_EXMemRead;
   logic [4:0] ID_EXRegDst;
   logic       EX_MemMemRead;
   logic [4:0] EX_MemRegDst;
   logic       PCWrite;
   logic       IF_IDWrite;
   logic       HazardDetect_Mux;
   logic       IF_IDFlush;

   modport master (
      output IF_IDRs, IF_IDRt, IF_IDUsesRt, IF_IDBranch, IF_IDJumpReg,
             BranchTaken, Jump, ID_EXRegWrite, ID_EXMemRead, ID_EXRegDst,
             EX_MemMemRead, EX_MemRegDst,
      input  PCWrite, IF_IDWrite, HazardDetect_Mux, IF_IDFlush
   );

   modport slave (
      input  IF_IDRs, IF_IDRt, IF_IDUsesRt, IF_IDBranch, IF_IDJumpReg,
             BranchTaken, Jump, ID_EXRegWrite, ID_EXMemRead, ID_EXRegDst,
             EX_MemMemRead, EX_MemRegDst,
      output PCWrite, IF_IDWrite, HazardDetect_Mux, IF_IDFlush
   );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_sequencer_calc.sv
// ============================================================================
// Module : hazard_stall_calc
// Brief  : Combinational stall-length (0..2) computation from the ID operands
//          against the ID/EX and EX/MEM destinations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_calc
   import hazard_stall_sequencer_pkg::*;
(
   input  logic [4:0] IF_IDRs,
   input  logic [4:0] IF_IDRt,
   input  logic       IF_IDUsesRt,
   input  logic       IF_IDBranch,
   input  logic       IF_IDJumpReg,
   input  logic       ID_EXRegWrite,
   input  logic       ID_EXMemRead,
   input  logic [4:0] ID_EXRegDst,
   input  logic       EX_MemMemRead,
   input  logic [4:0] EX_MemRegDst,
   output logic [1:0] stall_n
);

   logic use_rt;
   logic match_ex;
   logic match_mem;
   logic br_like;

   always_comb begin
      // jr only reads rs, whatever the rt field happens to hold.
      use_rt    = IF_IDUsesRt && !IF_IDJumpReg;
      match_ex  = reg_match(ID_EXRegDst, IF_IDRs, IF_IDRt, use_rt);
      match_mem = reg_match(EX_MemRegDst, IF_IDRs, IF_IDRt, use_rt);
      br_like   = IF_IDBranch || IF_IDJumpReg;

      stall_n = 2'd0;
      if (ID_EXMemRead && match_ex && (stall_n < LOAD_USE_STALL))
         stall_n = LOAD_USE_STALL;
      if (br_like && ID_EXRegWrite && !ID_EXMemRead && match_ex && (stall_n < BR_ALU_STALL))
         stall_n = BR_ALU_STALL;
      if (br_like && EX_MemMemRead && match_mem && (stall_n < BR_LOAD_MEM_STALL))
         stall_n = BR_LOAD_MEM_STALL;
      if (br_like && ID_EXMemRead && match_ex && (stall_n < BR_LOAD_EX_STALL))
         stall_n = BR_LOAD_EX_STALL;
   end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_sequencer.sv
// ============================================================================
// Module : hazard_stall_sequencer
// Brief  : Decode-stage stall/flush sequencer: PC/IF-ID enables, ID/EX bubble
//          select and IF/ID flush. Optional STALL_COUNTER_EN builds a
//          saturating stall-cycle counter on StallCycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_sequencer
   import hazard_stall_sequencer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   hazard_stall_sequencer_if.slave bus,
   output logic [CNT_W-1:0]     StallCycles
);

   state_e     state_q, state_d;
   logic [1:0] rem_q, rem_d;
   logic [1:0] stall_n;

   hazard_stall_calc u_calc (
      .IF_IDRs      (bus.IF_IDRs),
      .IF_IDRt      (bus.IF_IDRt),
      .IF_IDUsesRt  (bus.IF_IDUsesRt),
      .IF_IDBranch  (bus.IF_IDBranch),
      .IF_IDJumpReg (bus.IF_IDJumpReg),
      .ID_EXRegWrite(bus.ID_EXRegWrite),
      .ID_EXMemRead (bus.ID_EXMemRead),
      .ID_EXRegDst  (bus.ID_EXRegDst),
      .EX_MemMemRead(bus.EX_MemMemRead),
      .EX_MemRegDst (bus.EX_MemRegDst),
      .stall_n      (stall_n)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         RUN: begin
            if (stall_n == BR_LOAD_EX_STALL) begin
               state_d = STALL;
               rem_d   = stall_n - 2'd2;
            end
         end
         STALL: begin
            if (rem_q == 2'd0) state_d = RUN;
            else               rem_d   = rem_q - 2'd1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= RUN;
         rem_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // A stall always wins over a flush; the branch re-resolves afterwards.
   always_comb begin
      bus.PCWrite          = 1'b1;
      bus.IF_IDWrite       = 1'b1;
      bus.HazardDetect_Mux = 1'b0;
      bus.IF_IDFlush       = 1'b0;
      if (Reset) begin
         if ((state_q == STALL) || (stall_n != 2'd0)) begin
            bus.PCWrite          = 1'b0;
            bus.IF_IDWrite       = 1'b0;
            bus.HazardDetect_Mux = 1'b1;
         end else begin
            bus.IF_IDFlush = (bus.IF_IDBranch && bus.BranchTaken) ||
                             bus.Jump || bus.IF_IDJumpReg;
         end
      end
   end

`ifdef STALL_COUNTER_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!bus.PCWrite && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign StallCycles = stall_cnt_q;
`else
   assign StallCycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_sequencer.sv
// ============================================================================
// Module : tb_hazard_stall_sequencer
// Brief  : Directed self-checking bench for hazard_stall_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_sequencer;

   localparam int CNT_W = 16;
   // {PCWrite, IF_IDWrite, HazardDetect_Mux, IF_IDFlush}
   localparam logic [3:0] O_RUN   = 4'b1100;
   localparam logic [3:0] O_FLUSH = 4'b1101;
   localparam logic [3:0] O_STALL = 4'b0010;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic [CNT_W-1:0] StallCycles;
   int               checks = 0;
   int               errors = 0;

   hazard_stall_sequencer_if bus ();

   hazard_stall_sequencer #(.CNT_W(CNT_W)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .bus        (bus.slave),
      .StallCycles(StallCycles)
   );

   always #5 Clk = ~Clk;

   logic [3:0] outs;
   assign outs = {bus.PCWrite, bus.IF_IDWrite, bus.HazardDetect_Mux, bus.IF_IDFlush};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.IF_IDRs = 5'd0;       bus.IF_IDRt = 5'd0;        bus.IF_IDUsesRt = 1'b0;
      bus.IF_IDBranch = 1'b0;   bus.IF_IDJumpReg = 1'b0;   bus.BranchTaken = 1'b0;
      bus.Jump = 1'b0;          bus.ID_EXRegWrite = 1'b0;  bus.ID_EXMemRead = 1'b0;
      bus.ID_EXRegDst = 5'd0;   bus.EX_MemMemRead = 1'b0;  bus.EX_MemRegDst = 5'd0;
   endtask

   // Advance to just after the next rising edge, then present clean inputs.
   task automatic tick();
      @(posedge Clk);
      #1;
      clear_inputs();
   endtask

   task automatic branch_after_load();
      bus.IF_IDBranch = 1'b1; bus.IF_IDRt = 5'd9; bus.IF_IDUsesRt = 1'b1;
      bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd9;
   endtask

   initial begin
      clear_inputs();
      #2;
      check("reset_outs", outs, O_RUN);
      check("reset_cnt", StallCycles, 0);
      #1 Reset = 1'b1;

      tick(); #1 check("idle", outs, O_RUN);

      tick(); bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd8; bus.IF_IDRs = 5'd8;
      #1 check("load_use_rs", outs, O_STALL);
      tick(); #1 check("load_use_after", outs, O_RUN);

      tick(); bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd3; bus.IF_IDRt = 5'd3; bus.IF_IDUsesRt = 1'b1;
      #1 check("load_use_rt", outs, O_STALL);
      tick(); bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd3; bus.IF_IDRt = 5'd3;
      #1 check("load_rt_unused", outs, O_RUN);

      tick(); branch_after_load();
      #1 check("br_load_c1", outs, O_STALL);
      tick(); #1 check("br_load_c2", outs, O_STALL);
      tick(); #1 check("br_load_done", outs, O_RUN);

      tick(); bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd0; bus.IF_IDRs = 5'd0;
      #1 check("reg_zero", outs, O_RUN);

      tick(); bus.IF_IDBranch = 1'b1; bus.BranchTaken = 1'b1;
      #1 check("br_taken_flush", outs, O_FLUSH);
      tick(); #1 check("flush_one_cycle", outs, O_RUN);

      tick(); bus.IF_IDBranch = 1'b1; bus.BranchTaken = 1'b1;
      bus.ID_EXRegWrite = 1'b1; bus.ID_EXRegDst = 5'd5; bus.IF_IDRs = 5'd5;
      #1 check("br_alu_stall", outs, O_STALL);
      tick(); #1 check("br_alu_after", outs, O_RUN);

      tick(); bus.ID_EXRegWrite = 1'b1; bus.ID_EXRegDst = 5'd5; bus.IF_IDRs = 5'd5;
      #1 check("alu_no_branch", outs, O_RUN);

      tick(); bus.Jump = 1'b1;
      #1 check("jump_flush", outs, O_FLUSH);

      tick(); bus.IF_IDJumpReg = 1'b1; bus.IF_IDRt = 5'd7; bus.IF_IDUsesRt = 1'b1;
      bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd7;
      #1 check("jr_rt_ignored", outs, O_FLUSH);

      tick(); bus.IF_IDJumpReg = 1'b1; bus.IF_IDRs = 5'd4;
      bus.EX_MemMemRead = 1'b1; bus.EX_MemRegDst = 5'd4;
      #1 check("jr_mem_load", outs, O_STALL);
      tick(); #1 check("jr_mem_after", outs, O_RUN);

      tick(); branch_after_load();
      #1 check("rst_pre_stall", outs, O_STALL);
      tick(); #1 check("rst_in_stall", outs, O_STALL);
      Reset = 1'b0;
      #1 check("rst_mid_outs", outs, O_RUN);
      check("rst_mid_cnt", StallCycles, 0);
      #1 Reset = 1'b1;
      tick(); #1 check("rst_back_run", outs, O_RUN);

      // 1 (load-use) + 2 (branch after load) + 1 (branch after MEM load)
      tick(); bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd8; bus.IF_IDRs = 5'd8;
      tick(); branch_after_load();
      tick();
      tick(); bus.IF_IDBranch = 1'b1; bus.IF_IDRs = 5'd6;
      bus.EX_MemMemRead = 1'b1; bus.EX_MemRegDst = 5'd6;
      tick(); #1 check("seq_run", outs, O_RUN);
`ifdef STALL_COUNTER_EN
      check("cnt_four", StallCycles, 4);
      bus.ID_EXMemRead = 1'b1; bus.ID_EXRegDst = 5'd8; bus.IF_IDRs = 5'd8;
      repeat (65540) @(posedge Clk);
      #1 check("cnt_saturate", StallCycles, 16'hFFFF);
      clear_inputs();
`else
      check("cnt_tied_zero", StallCycles, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
